// File: rtl/uart_tx_block.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks, and all outputs come directly from flops.
module uart_tx_block #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [7:0]       CNT_MAX  = 8'(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   tx_out_q, tx_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   roll;

    assign roll = (cnt_q == CNT_MAX);

    // The next line value is always decided one edge early, so tx_out stays a plain flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_out_d = tx_out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = roll ? 8'd1 : cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_start) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ 1'(PARITY_ODD);
                    cnt_d    = 8'd1;
                    idx_d    = '0;
                    tx_out_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (roll) begin
                    state_d  = S_DATA;
                    tx_out_d = shift_q[0];
                end
            end
            S_DATA: begin
                if (roll) begin
                    if (idx_q == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_d  = S_PARITY;
                            tx_out_d = parity_q;
                        end else begin
                            state_d  = S_STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        tx_out_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (roll) begin
                    state_d  = S_STOP;
                    tx_out_d = 1'b1;
                end
            end
            S_STOP: begin
                if (roll) begin
                    state_d  = S_IDLE;
                    cnt_d    = 8'd0;
                    idx_d    = '0;
                    tx_out_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = 8'd0;
                tx_out_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block: one plain instance plus even- and odd-parity instances.
// Outputs are packed as {tx_out, tx_busy, tx_done} and compared cycle by cycle against frames built here.
module tb_uart_tx_block;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic out_p, busy_p, done_p;
    logic out_e, busy_e, done_e;
    logic out_o, busy_o, done_o;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    uart_tx_block #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_plain (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_out(out_p), .tx_busy(busy_p), .tx_done(done_p));

    uart_tx_block #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_out(out_e), .tx_busy(busy_e), .tx_done(done_e));

    uart_tx_block #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_out(out_o), .tx_busy(busy_o), .tx_done(done_o));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the inputs, then advances to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d);
        rst      = r;
        tx_start = s;
        tx_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] outsOf(input int sel);
        case (sel)
            1:       return {out_e, busy_e, done_e};
            2:       return {out_o, busy_o, done_o};
            default: return {out_p, busy_p, done_p};
        endcase
    endfunction

    // Called right after the accepting edge; walks the whole frame and checks the done cycle.
    task automatic checkFrame(input string name, input int sel, input logic [7:0] data,
                              input int parBits, input logic odd, input int pokeAt,
                              input logic [7:0] pokeData, input int releaseAt, input int abortAt);
        logic [10:0] bits;
        int          nbits;
        nbits   = 8 + parBits + 2;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        if (parBits != 0) bits[9] = (^data) ^ odd;
        for (int j = 0; j < nbits * CPB; j++) begin
            if (j == abortAt) begin
                rst = 1'b1;
                return;
            end
            if (j == pokeAt) begin
                tx_start = 1'b1;
                tx_data  = pokeData;
            end
            if (j == releaseAt) tx_start = 1'b0;
            checkOutput($sformatf("%s_c%0d", name, j), 32'(outsOf(sel)), 32'({bits[j / CPB], 2'b10}));
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("%s_done", name), 32'(outsOf(sel)), 32'(3'b101));
    endtask

    initial begin
        // Reset held with tx_start asserted: nothing may start.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b1, 8'hAA);
            for (int s = 0; s < 3; s++)
                checkOutput($sformatf("reset_c%0d_s%0d", c, s), 32'(outsOf(s)), 32'(3'b100));
        end
        applyStimulus(1'b0, 1'b0, 8'hAA);
        checkOutput("post_reset_idle", 32'(outsOf(0)), 32'(3'b100));

        // Frame A5, with an FF request arriving mid-frame that must be ignored.
        $display("[TB] frame A5 with ignored mid-frame request");
        applyStimulus(1'b0, 1'b1, 8'hA5);
        tx_start = 1'b0;
        checkFrame("fA5", 0, 8'hA5, 0, 1'b0, 30, 8'hFF, 40, -1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 8'hFF);
            checkOutput($sformatf("idle_after_A5_c%0d", c), 32'(outsOf(0)), 32'(3'b100));
        end

        // tx_start held high: back-to-back frames with exactly one idle cycle (the done cycle).
        $display("[TB] back-to-back 3C frames");
        applyStimulus(1'b0, 1'b1, 8'h3C);
        checkFrame("f3C_a", 0, 8'h3C, 0, 1'b0, -1, 8'h00, -1, -1);
        applyStimulus(1'b0, 1'b1, 8'h3C);
        checkFrame("f3C_b", 0, 8'h3C, 0, 1'b0, -1, 8'h00, 5, -1);
        applyStimulus(1'b0, 1'b0, 8'h3C);
        checkOutput("idle_after_3C", 32'(outsOf(0)), 32'(3'b100));

        // Reset at cycle 45 of a frame aborts it without a done pulse.
        $display("[TB] mid-frame reset then clean 5A frame");
        applyStimulus(1'b0, 1'b1, 8'h5A);
        tx_start = 1'b0;
        checkFrame("f5A_abort", 0, 8'h5A, 0, 1'b0, -1, 8'h00, -1, 45);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        checkOutput("abort_reset", 32'(outsOf(0)), 32'(3'b100));
        for (int c = 0; c < 60; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h5A);
            checkOutput($sformatf("abort_quiet_c%0d", c), 32'(outsOf(0)), 32'(3'b100));
        end
        applyStimulus(1'b0, 1'b1, 8'h5A);
        tx_start = 1'b0;
        checkFrame("f5A", 0, 8'h5A, 0, 1'b0, -1, 8'h00, -1, -1);

        // Parity frames for 07: even parity bit 1, odd parity bit 0, 110 cycles each.
        $display("[TB] parity frames for 07");
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h07);
        tx_start = 1'b0;
        checkFrame("par_even", 1, 8'h07, 1, 1'b0, -1, 8'h00, -1, -1);
        applyStimulus(1'b0, 1'b1, 8'h07);
        tx_start = 1'b0;
        checkFrame("par_odd", 2, 8'h07, 1, 1'b1, -1, 8'h00, -1, -1);
        applyStimulus(1'b0, 1'b0, 8'h07);
        checkOutput("par_odd_idle", 32'(outsOf(2)), 32'(3'b100));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
